// File: rtl/regs_bank_if.sv
// regs_bank_if: sample handshake, write-back bus and register outputs of regs_bank
interface regs_bank_if #(parameter int N_PTS = 16, parameter int DW = 16);
  localparam int W = 2*DW*N_PTS;
  logic clr, in_valid, in_ready, x_release, wb_en, x_full;
  logic [DW-1:0] in_re, in_im;
  logic [1:0] wb_sel;
  logic [W-1:0] wb_data, r_x, r_a, r_b, r_c, r_d;
  logic [3:0] x_cnt;
  modport master(output clr, in_valid, in_re, in_im, x_release, wb_en, wb_sel, wb_data,
                 input in_ready, r_x, r_a, r_b, r_c, r_d, x_full, x_cnt);
  modport slave(input clr, in_valid, in_re, in_im, x_release, wb_en, wb_sel, wb_data,
                output in_ready, r_x, r_a, r_b, r_c, r_d, x_full, x_cnt);
endinterface

// File: rtl/regs_bank.sv
// regs_bank: input-frame register R_x with load/full handshake plus four stage registers
module regs_bank #(parameter int N_PTS = 16, parameter int DW = 16) (
  input logic clk,
  input logic rst_n,
  regs_bank_if.slave bus
);
  localparam int W = 2*DW*N_PTS;
  localparam logic [3:0] LAST = 4'(N_PTS-1);
  typedef enum logic {LOAD, FULL} state_t;
  state_t state, state_nx;
  logic [W-1:0] r_x, r_a, r_b, r_c, r_d;
  logic [3:0] x_cnt;
  logic acc;
  always_comb begin
    acc = bus.in_valid && state == LOAD;
    state_nx = (acc && x_cnt == LAST) ? FULL : (state == FULL && bus.x_release) ? LOAD : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      x_cnt <= '0;
      r_x <= '0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else if (bus.clr) begin
      state <= LOAD;
      x_cnt <= '0;
      r_x <= '0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        r_x[x_cnt*(2*DW) +: 2*DW] <= {bus.in_re, bus.in_im};
        x_cnt <= (x_cnt == LAST) ? 4'd0 : x_cnt + 4'd1;
      end
      if (bus.wb_en && bus.wb_sel == 2'd0) r_a <= bus.wb_data;
      if (bus.wb_en && bus.wb_sel == 2'd1) r_b <= bus.wb_data;
      if (bus.wb_en && bus.wb_sel == 2'd2) r_c <= bus.wb_data;
      if (bus.wb_en && bus.wb_sel == 2'd3) r_d <= bus.wb_data;
    end
  end
  assign bus.in_ready = state == LOAD;
  assign bus.x_full = state == FULL;
  assign bus.x_cnt = x_cnt;
  assign bus.r_x = r_x;
  assign bus.r_a = r_a;
  assign bus.r_b = r_b;
  assign bus.r_c = r_c;
  assign bus.r_d = r_d;
endmodule

// File: tb/tb_regs_bank.sv
// tb_regs_bank: scoreboard bench; a per-point reference model predicts every cycle's register state
module tb_regs_bank;
  localparam int N = 16;
  localparam int DW = 16;
  localparam int W = 2*DW*N;
  typedef struct {
    logic [W-1:0] x, a, b, c, d;
    logic [3:0] cnt;
    logic full, ready;
  } snap_t;
  logic clk = 0;
  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;
  snap_t sb[$];
  logic [31:0] m_x [N];
  logic [W-1:0] m_a, m_b, m_c, m_d, gapfree, pat;
  int m_cnt;
  bit m_full;
  regs_bank_if #(.N_PTS(N), .DW(DW)) bus();
  regs_bank #(.N_PTS(N), .DW(DW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] pack_x();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[32*k +: 32] = m_x[k];
    return v;
  endfunction
  function automatic snap_t snap();
    snap_t s;
    s.x = pack_x();
    s.a = m_a;
    s.b = m_b;
    s.c = m_c;
    s.d = m_d;
    s.cnt = 4'(m_cnt);
    s.full = m_full;
    s.ready = !m_full;
    return s;
  endfunction
  task automatic model_zero();
    for (int k = 0; k < N; k++) m_x[k] = '0;
    {m_a, m_b, m_c, m_d} = '0;
    m_cnt = 0;
    m_full = 0;
  endtask
  task automatic pop_cmp(string tag);
    snap_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing want entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".r_x"}, bus.r_x, e.x);
      chk({tag, ".r_a"}, bus.r_a, e.a);
      chk({tag, ".r_b"}, bus.r_b, e.b);
      chk({tag, ".r_c"}, bus.r_c, e.c);
      chk({tag, ".r_d"}, bus.r_d, e.d);
      chk({tag, ".x_cnt"}, W'(bus.x_cnt), W'(e.cnt));
      chk({tag, ".x_full"}, W'(bus.x_full), W'(e.full));
      chk({tag, ".in_ready"}, W'(bus.in_ready), W'(e.ready));
    end
  endtask
  task automatic idle();
    bus.clr = 0;
    bus.in_valid = 0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.x_release = 0;
    bus.wb_en = 0;
    bus.wb_sel = '0;
    bus.wb_data = '0;
  endtask
  task automatic cyc(string tag, bit v, logic [15:0] re, logic [15:0] im, bit rel = 0,
                     bit we = 0, logic [1:0] sel = 0, logic [W-1:0] wd = '0, bit c = 0);
    bus.in_valid = v;
    bus.in_re = re;
    bus.in_im = im;
    bus.x_release = rel;
    bus.wb_en = we;
    bus.wb_sel = sel;
    bus.wb_data = wd;
    bus.clr = c;
    if (c) model_zero();
    else begin
      if (!m_full && v) begin
        m_x[m_cnt] = {re, im};
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0;
          m_full = 1;
        end
      end else if (m_full && rel) m_full = 0;
      if (we && sel == 2'd0) m_a = wd;
      if (we && sel == 2'd1) m_b = wd;
      if (we && sel == 2'd2) m_c = wd;
      if (we && sel == 2'd3) m_d = wd;
    end
    sb.push_back(snap());
    @(posedge clk);
    #1;
    pop_cmp(tag);
    idle();
  endtask
  initial begin
    rst_n = 1;
    idle();
    model_zero();
    #1 rst_n = 0;
    #1;
    sb.push_back(snap());
    pop_cmp("reset");
    #6 rst_n = 1;
    for (int k = 0; k < N; k++) cyc("stream", 1, 16'(k), 16'(-k));
    chk("full16", W'(bus.x_full), W'(1'b1));
    chk("pt5", W'(bus.r_x[5*32 +: 32]), W'(32'h0005_FFFB));
    chk("rdy_full", W'(bus.in_ready), W'(1'b0));
    cyc("17th", 1, 16'h0011, 16'h0022);
    chk("pt0_kept", W'(bus.r_x[31:0]), W'(32'h0));
    cyc("rel_valid", 1, 16'h0777, 16'h0888, 1);
    chk("rdy_rel", W'(bus.in_ready), W'(1'b1));
    chk("cnt_rel", W'(bus.x_cnt), W'(4'd0));
    cyc("after_rel", 1, 16'h1234, 16'h5678);
    chk("pt0_new", W'(bus.r_x[31:0]), W'(32'h1234_5678));
    chk("pt1_old", W'(bus.r_x[63:32]), W'(32'h0001_FFFF));
    cyc("wb_b", 0, 0, 0, 0, 1, 2'd1, {N{32'hDEAD_BEEF}});
    cyc("clr_mix", 1, 16'h4, 16'h4, 0, 1, 2'd3, {W/8{8'h3C}}, 1);
    chk("clr_rb", bus.r_b, '0);
    chk("clr_cnt", W'(bus.x_cnt), W'(4'd0));
    for (int k = 0; k < N; k++) cyc("nogap", 1, 16'(3*k+1), ~16'(k));
    gapfree = pack_x();
    cyc("rel1", 0, 0, 0, 1);
    for (int k = 0; k < N; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) cyc("gap", 0, 16'hBAD0, 16'hBAD1);
      cyc("gapped", 1, 16'(3*k+1), ~16'(k));
    end
    chk("gap_rx", bus.r_x, gapfree);
    chk("gap_full", W'(bus.x_full), W'(1'b1));
    pat = {W/8{8'hA5}};
    cyc("rel2", 0, 0, 0, 1, 1, 2'd0, {N{32'h1111_2222}});
    cyc("wb_b2", 0, 0, 0, 0, 1, 2'd1, {N{32'h3333_4444}});
    cyc("wb_d", 0, 0, 0, 0, 1, 2'd3, {N{32'h5555_6666}});
    for (int k = 0; k < N-1; k++) cyc("ld15", 1, 16'(k+100), 16'(k));
    cyc("wb_c_last", 1, 16'h7FFF, 16'h8000, 0, 1, 2'd2, pat);
    chk("rc_pat", bus.r_c, pat);
    chk("ra_kept", bus.r_a, {N{32'h1111_2222}});
    chk("full39", W'(bus.x_full), W'(1'b1));
    cyc("rel3", 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) cyc("ld7", 1, 16'(k+50), 16'(k+60));
    #3 rst_n = 0;
    #1;
    model_zero();
    sb.push_back(snap());
    pop_cmp("async");
    chk("rdy_async", W'(bus.in_ready), W'(1'b1));
    #3 rst_n = 1;
    cyc("post_rst", 1, 16'hABCD, 16'h0123);
    chk("pt0_rst", W'(bus.r_x[31:0]), W'(32'hABCD_0123));
    chk("cnt_rst", W'(bus.x_cnt), W'(4'd1));
    cyc("pre_clr", 1, 16'h0002, 16'h0003, 0, 1, 2'd0, {N{32'hCAFE_F00D}});
    cyc("clr_all", 1, 16'h0009, 16'h0009, 1, 1, 2'd0, {N{32'h0BAD_0BAD}}, 1);
    chk("clr_rx", bus.r_x, '0);
    chk("clr_ra", bus.r_a, '0);
    chk("clr_rdy", W'(bus.in_ready), W'(1'b1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regs_bank.md
REGS_BANK -- requirements
Module: regs_bank

Interface
REQ-001 Parameter: N_PTS, default 16, number of complex points held per register.
REQ-002 Parameter: DW, default 16, bit width of each real or imaginary part, two's complement.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset is asynchronous and active-low.
REQ-005 clr  in  1  synchronous clear of the whole bank.
REQ-006 in_valid  in  1  an input sample is present.
REQ-007 in_ready  out  1  the bank can accept an input sample.
REQ-008 in_re  in  DW  real part of the input sample.
REQ-009 in_im  in  DW  imaginary part of the input sample.
REQ-010 x_release  in  1  pulse; the consumer is done with R_x and the next frame may load.
REQ-011 wb_en  in  1  write the butterfly/MAC result into the selected stage register.
REQ-012 wb_sel  in  2  stage-register select: 00 = R_A, 01 = R_B, 10 = R_C, 11 = R_D.
REQ-013 wb_data  in  2*DW*N_PTS  stage result, in the same packing as R_x.
REQ-014 R_x, R_A, R_B, R_C, R_D  out  2*DW*N_PTS each  input-frame register and four stage registers; these feed the MAC input mux.
REQ-015 x_full  out  1  R_x holds a complete frame.
REQ-016 x_cnt  out  4  number of samples loaded into the current frame.

Function
REQ-017 Packing: point k occupies bits [2*DW*k+2*DW-1 : 2*DW*k]; the real part is in the upper DW bits and the imaginary part is in the lower DW bits.
REQ-018 FSM has two states. LOAD: in_ready=1, x_full=0. FULL: in_ready=0, x_full=1.
REQ-019 A sample is accepted on an edge where in_valid=1 and in_ready=1; in_re and in_im are written into point x_cnt of R_x, and x_cnt increments.
REQ-020 On acceptance with x_cnt=N_PTS-1, x_cnt wraps to 0 and the FSM moves LOAD->FULL; x_full rises on the same edge that writes the last point.
REQ-021 In FULL, in_valid is ignored and R_x does not change.
REQ-022 An edge in FULL with x_release=1 moves the FSM to LOAD; no sample is accepted on that edge.
REQ-023 x_release in LOAD has no effect.
REQ-024 A new frame overwrites R_x point by point; points not yet overwritten keep the previous frame's values.
REQ-025 On an edge with wb_en=1, the register chosen by wb_sel is written with wb_data.
REQ-026 A write-back does not depend on FSM state or on input acceptance; both may occur on the same edge.
REQ-027 Registers not selected by wb_sel hold their values.
REQ-028 Data is stored without arithmetic modification: no rounding, no saturation, no sign change.
REQ-029 Each output is driven directly from a register, so the registered value appears after 1 cycle of latency and the outputs have no combinational path from the inputs.
REQ-030 in_ready is the exception to REQ-029: it is decoded from FSM state only, never from in_valid.
REQ-031 clr=1 on an edge zeroes R_x and R_A to R_D, sets x_cnt=0, and sets the FSM to LOAD.
REQ-032 clr has priority over acceptance, x_release and wb_en on the same edge.

Reset
REQ-033 rst_n=0 immediately clears, without waiting for clk: R_x, R_A, R_B, R_C, R_D = 0; x_cnt=0; FSM=LOAD; in_ready=1; x_full=0.
REQ-034 Reset asserted mid-frame discards the partial frame; the first accepted sample after release is stored at point 0.
REQ-035 Deassertion of rst_n is synchronous to clk in the surrounding logic; no input is accepted on the deassertion edge itself.

Verification
REQ-036 Stream 16 samples, re=k, im=-k, with in_valid held high: required x_full=1 after edge 16; point 5 bits = 0x0005_FFFB; in_ready=0 afterwards; a 17th sample is not accepted.
REQ-037 Drop in_valid low for random gaps while loading: required R_x identical to the gap-free run and x_cnt counting only accepted samples.
REQ-038 Assert x_release while in FULL and present in_valid on the same cycle: required that no acceptance occurs; the next sample lands at point 0 with in_ready=1.
REQ-039 wb_en=1, wb_sel=10, wb_data=0xA5 pattern, coinciding with the 16th input sample: required R_C = pattern, R_A/R_B/R_D unchanged, x_full=1.
REQ-040 Pulse rst_n low asynchronously between edges after 7 samples: required all outputs zero immediately and in_ready=1; the next load starts at point 0.
REQ-041 clr together with wb_en and an accepted sample: required all registers zero, x_cnt=0, FSM in LOAD.
